// File: rtl/rc_capture_peripheral_pkg.sv
// Shared definitions for the RC capture peripheral: register map, reply
// sizes, per-channel state encoding and the reply-size helper.
package rc_capture_pkg;

  localparam logic [7:0] RC_ADDR_WIDTH0  = 8'd0;
  localparam logic [7:0] RC_ADDR_STATUS  = 8'd6;
  localparam logic [7:0] RC_ADDR_TIMEOUT = 8'd7;

  localparam logic [2:0] RC_SIZE_WIDTH = 3'd2;
  localparam logic [2:0] RC_SIZE_BYTE  = 3'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    ABORT = 2'd2
  } rc_ch_state_t;

  // Width registers are two bytes wide, everything else replies with one byte.
  function automatic logic [2:0] rc_reg_size(input logic [7:0] addr, input int num_ch);
    logic [2:0] size_v;
    if (int'(addr) < num_ch) begin
      size_v = RC_SIZE_WIDTH;
    end else begin
      size_v = RC_SIZE_BYTE;
    end
    return size_v;
  endfunction

endpackage

// File: rtl/rc_capture_peripheral_if.sv
// Register-bus control lines (address, direction, select) as seen by the
// initiator (master) and by a responder peripheral (slave).
interface rc_capture_peripheral_if;
  logic [7:0] reg_addr;
  logic       rw;
  logic       select;

  modport master (output reg_addr, output rw, output select);
  modport slave  (input reg_addr, input rw, input select);
endinterface

// File: rtl/rc_capture_peripheral_channel.sv
// One RC channel: pin synchronizer, edge detector, pulse-width FSM and
// staleness age counter. Width is reported in microseconds.
module rc_channel_capture
  import rc_capture_pkg::*;
#(
  parameter int MAX_WIDTH_US = 3000
) (
  input  logic        clk_12MHz,
  input  logic        reset,
  input  logic        rc_in,
  input  logic        us_tick,
  input  logic        ms_tick,
  input  logic [7:0]  timeout_ms,
  output logic [15:0] width,
  output logic        valid
);

  logic         sync1_r;
  logic         sync2_r;
  logic         prev_r;
  logic         rise_s;
  logic         fall_s;
  logic         timed_out_s;
  rc_ch_state_t state_r;
  logic [15:0]  cnt_r;
  logic         armed_r;
  logic [7:0]   age_r;

  // Synchronizer and edge history run through reset so a level held across reset is never seen as an edge.
  always_ff @(posedge clk_12MHz) begin
    sync1_r <= rc_in;
    sync2_r <= sync1_r;
    prev_r  <= sync2_r;
  end

  // Edge decode and stale-result detection.
  always_comb begin
    rise_s      = sync2_r & ~prev_r;
    fall_s      = ~sync2_r & prev_r;
    timed_out_s = (timeout_ms != 8'd0) && (age_r >= timeout_ms);
  end

  // Pulse FSM with age counter; later assignments in this block let a capture override a same-cycle timeout.
  always_ff @(posedge clk_12MHz) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 16'd0;
      armed_r <= 1'b0;
      width   <= 16'd0;
      valid   <= 1'b0;
      age_r   <= 8'd0;
    end else begin
      if (ms_tick && (age_r != 8'd255)) begin
        age_r <= age_r + 8'd1;
      end
      if (timed_out_s) begin
        valid <= 1'b0;
        width <= 16'd0;
      end
      case (state_r)
        IDLE: begin
          if (rise_s) begin
            cnt_r   <= 16'd0;
            armed_r <= 1'b1;
            state_r <= HIGH;
          end
        end
        HIGH: begin
          if (fall_s) begin
            if (armed_r) begin
              width <= cnt_r;
              valid <= 1'b1;
              age_r <= 8'd0;
            end
            armed_r <= 1'b0;
            state_r <= IDLE;
          end else if (us_tick) begin
            if (cnt_r >= 16'(MAX_WIDTH_US)) begin
              width   <= 16'd0;
              valid   <= 1'b0;
              armed_r <= 1'b0;
              state_r <= ABORT;
            end else begin
              cnt_r <= cnt_r + 16'd1;
            end
          end
        end
        ABORT: begin
          if (fall_s) begin
            state_r <= IDLE;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/rc_capture_peripheral.sv
// RC receiver capture peripheral: microsecond/millisecond timebase, NUM_CH
// capture channels and the register-bus responder with a snapshot read latch.
module rc_capture_peripheral
  import rc_capture_pkg::*;
#(
  parameter int CLK_PER_US         = 12,
  parameter int NUM_CH             = 6,
  parameter int MAX_WIDTH_US       = 3000,
  parameter int TIMEOUT_MS_DEFAULT = 50
) (
  input  logic                  clk_12MHz,
  input  logic                  reset,
  rc_capture_peripheral_if.slave bus,
  inout  tri   [31:0]           databus,
  output tri   [2:0]            reg_size,
  input  logic [NUM_CH-1:0]     rc_in
);

  localparam int PRE_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

  logic [PRE_W-1:0]  us_cnt_r;
  logic [9:0]        ms_cnt_r;
  logic              us_tick_s;
  logic              ms_tick_s;
  logic [7:0]        timeout_ms_r;
  logic              sel_q_r;
  logic [31:0]       rd_latch_r;
  logic [31:0]       rd_val_s;
  logic              access_start_s;
  logic              drive_s;
  logic [15:0]       width_s [NUM_CH];
  logic [NUM_CH-1:0] valid_s;

  // Tick decode and bus-phase decode.
  always_comb begin
    us_tick_s      = (us_cnt_r == PRE_W'(CLK_PER_US - 1));
    ms_tick_s      = us_tick_s && (ms_cnt_r == 10'd999);
    access_start_s = bus.select & ~sel_q_r;
    drive_s        = bus.select & bus.rw & sel_q_r;
  end

  // Shared timebase: us prescaler and 1000-tick millisecond counter.
  always_ff @(posedge clk_12MHz) begin
    if (reset) begin
      us_cnt_r <= {PRE_W{1'b0}};
      ms_cnt_r <= 10'd0;
    end else begin
      if (us_tick_s) begin
        us_cnt_r <= {PRE_W{1'b0}};
        if (ms_cnt_r == 10'd999) begin
          ms_cnt_r <= 10'd0;
        end else begin
          ms_cnt_r <= ms_cnt_r + 10'd1;
        end
      end else begin
        us_cnt_r <= us_cnt_r + PRE_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    rc_channel_capture #(
      .MAX_WIDTH_US (MAX_WIDTH_US)
    ) u_ch (
      .clk_12MHz  (clk_12MHz),
      .reset      (reset),
      .rc_in      (rc_in[g]),
      .us_tick    (us_tick_s),
      .ms_tick    (ms_tick_s),
      .timeout_ms (timeout_ms_r),
      .width      (width_s[g]),
      .valid      (valid_s[g])
    );
  end

  // Register read mux; unmapped addresses read as zero.
  always_comb begin
    rd_val_s = 32'd0;
    case (bus.reg_addr)
      RC_ADDR_STATUS:  rd_val_s[NUM_CH-1:0] = valid_s;
      RC_ADDR_TIMEOUT: rd_val_s[7:0]        = timeout_ms_r;
      default: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (bus.reg_addr == (RC_ADDR_WIDTH0 + 8'(i))) begin
            rd_val_s = {16'd0, width_s[i]};
          end else begin
            rd_val_s = rd_val_s;
          end
        end
      end
    endcase
  end

  // Access edge tracking: one write and one read snapshot per select pulse.
  always_ff @(posedge clk_12MHz) begin
    if (reset) begin
      sel_q_r      <= 1'b0;
      timeout_ms_r <= 8'(TIMEOUT_MS_DEFAULT);
      rd_latch_r   <= 32'd0;
    end else begin
      sel_q_r <= bus.select;
      if (access_start_s && !bus.rw && (bus.reg_addr == RC_ADDR_TIMEOUT)) begin
        timeout_ms_r <= databus[7:0];
      end
      if (access_start_s && bus.rw) begin
        rd_latch_r <= rd_val_s;
      end
    end
  end

  assign databus  = drive_s ? rd_latch_r : {32{1'bz}};
  assign reg_size = bus.select ? rc_reg_size(bus.reg_addr, NUM_CH) : 3'bzzz;

endmodule

// File: tb/tb_rc_capture_peripheral.sv
// Randomised scoreboard bench for rc_capture_peripheral. Reads push an
// expectation from a time-based reference model; a negedge monitor pops and
// checks whenever the peripheral drives read data.
module tb_rc_capture_peripheral;
  import rc_capture_pkg::*;

  localparam int CLK_PER_US = 2;
  localparam int NUM_CH     = 6;
  localparam int MAX_US     = 3000;
  localparam int TO_DEF     = 50;

  logic              clk_12MHz = 1'b0;
  logic              reset     = 1'b1;
  logic [NUM_CH-1:0] rc_in     = '0;
  wire  [31:0]       databus;
  wire  [2:0]        reg_size;
  logic              tb_drv = 1'b0;
  logic [31:0]       tb_db  = 32'd0;

  assign databus = tb_drv ? tb_db : {32{1'bz}};
  pullup (databus);
  pullup (reg_size);

  rc_capture_peripheral_if bus_if ();

  rc_capture_peripheral #(
    .CLK_PER_US (CLK_PER_US), .NUM_CH (NUM_CH),
    .MAX_WIDTH_US (MAX_US), .TIMEOUT_MS_DEFAULT (TO_DEF)
  ) dut (
    .clk_12MHz (clk_12MHz), .reset (reset), .bus (bus_if.slave),
    .databus (databus), .reg_size (reg_size), .rc_in (rc_in)
  );

  always #5 clk_12MHz = ~clk_12MHz;

  int n_cmp  = 0;
  int n_fail = 0;
  longint cyc = 0;
  always @(posedge clk_12MHz) cyc <= cyc + 1;

  function automatic longint now_us();
    return cyc / CLK_PER_US;
  endfunction

  // ---------------- reference model ----------------
  int     m_width [NUM_CH];
  bit     m_valid [NUM_CH];
  bit     m_unsure[NUM_CH];
  longint m_cap_us[NUM_CH];
  int     m_timeout = TO_DEF;

  // 0: surely valid, 1: surely invalid, 2: within the timeout uncertainty window
  function automatic int ch_state(int ch);
    longint el;
    if (!m_valid[ch]) return 1;
    if (m_unsure[ch]) return 2;
    if (m_timeout == 0) return 0;
    el = now_us() - m_cap_us[ch];
    if (el < longint'(m_timeout - 1) * 1000) return 0;
    if (el >= longint'(m_timeout) * 1000 + 20) return 1;
    return 2;
  endfunction

  task automatic model_set_timeout(input int t);
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_state(c) == 1) m_valid[c] = 1'b0;
      else if (ch_state(c) == 2) m_unsure[c] = 1'b1;
    end
    m_timeout = t;
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_valid[c] = 1'b0; m_width[c] = 0; m_unsure[c] = 1'b0; m_cap_us[c] = 0;
    end
    m_timeout = TO_DEF;
  endtask

  typedef struct {
    logic [31:0] val;
    logic [31:0] mask;
    int          tol;
    logic [2:0]  size;
    string       name;
  } exp_t;

  exp_t sb[$];

  function automatic exp_t model_read(input logic [7:0] addr, input string name);
    exp_t e;
    int st;
    e.val = 32'd0; e.mask = 32'hFFFF_FFFF; e.tol = 0; e.name = name;
    e.size = (int'(addr) < NUM_CH) ? 3'd2 : 3'd1;
    if (int'(addr) < NUM_CH) begin
      st = ch_state(int'(addr));
      if (st == 0) begin e.val = 32'(m_width[int'(addr)]); e.tol = 1; end
      else if (st == 2) e.mask = 32'hFFFF_0000;
      else e.val = 32'd0;
    end else if (addr == 8'd6) begin
      for (int c = 0; c < NUM_CH; c++) begin
        st = ch_state(c);
        if (st == 0) e.val[c] = 1'b1;
        if (st == 2) e.mask[c] = 1'b0;
      end
    end else if (addr == 8'd7) begin
      e.val = 32'(m_timeout);
    end else begin
      e.val = 32'd0;
    end
    return e;
  endfunction

  // ---------------- comparison ----------------
  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp,
                     input logic [31:0] mask, input int tol);
    logic [31:0] g, x, d;
    g = got & mask; x = exp & mask;
    d = (g > x) ? (g - x) : (x - g);
    n_cmp++;
    if (d > 32'(tol)) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (mask 0x%0h, tol %0d)", name, got, exp, mask, tol);
    end
  endtask

  // ---------------- monitor ----------------
  bit   prev_sel = 1'b0;
  bit   in_acc   = 1'b0;
  bit   have_cur = 1'b0;
  exp_t cur;

  always @(negedge clk_12MHz) begin
    if (bus_if.select && bus_if.rw && prev_sel) begin
      if (!in_acc) begin
        in_acc = 1'b1;
        if (sb.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_read: got data 0x%0h, expected no access", databus);
        end else begin
          cur = sb.pop_front();
          have_cur = 1'b1;
          cmp({cur.name, ".size"}, {29'd0, reg_size}, {29'd0, cur.size}, 32'hFFFF_FFFF, 0);
        end
      end
      if (have_cur) cmp(cur.name, databus, cur.val, cur.mask, cur.tol);
    end else if (!bus_if.select) begin
      in_acc = 1'b0; have_cur = 1'b0;
    end
    prev_sel = bus_if.select;
  end

  // ---------------- stimulus tasks ----------------
  task automatic wait_us(input int us);
    repeat (us * CLK_PER_US) @(posedge clk_12MHz);
  endtask

  task automatic pulse(input int ch, input int us);
    @(posedge clk_12MHz); #1;
    rc_in[ch] = 1'b1;
    repeat (us * CLK_PER_US) @(posedge clk_12MHz);
    #1;
    rc_in[ch] = 1'b0;
    if (us > MAX_US) begin
      m_valid[ch] = 1'b0; m_width[ch] = 0; m_unsure[ch] = 1'b0;
    end else begin
      m_valid[ch] = 1'b1; m_width[ch] = us; m_unsure[ch] = 1'b0; m_cap_us[ch] = now_us();
    end
  endtask

  task automatic do_read(input logic [7:0] addr, input int hold, input string name);
    sb.push_back(model_read(addr, name));
    @(posedge clk_12MHz); #1;
    bus_if.reg_addr = addr; bus_if.rw = 1'b1; bus_if.select = 1'b1;
    repeat (hold) @(posedge clk_12MHz);
    #1;
    bus_if.select = 1'b0; bus_if.rw = 1'b0;
    @(posedge clk_12MHz);
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [31:0] d0, input logic [31:0] d1,
                          input int cycles);
    @(posedge clk_12MHz); #1;
    bus_if.reg_addr = addr; bus_if.rw = 1'b0; bus_if.select = 1'b1;
    tb_db = d0; tb_drv = 1'b1;
    @(posedge clk_12MHz); #1;
    tb_db = d1;
    repeat (cycles - 1) @(posedge clk_12MHz);
    #1;
    bus_if.select = 1'b0; tb_drv = 1'b0;
    if (addr == 8'd7) model_set_timeout(int'(d0[7:0]));
    @(posedge clk_12MHz);
  endtask

  task automatic check_idle_z(input string name);
    @(negedge clk_12MHz);
    cmp({name, ".databus_z"}, databus, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    cmp({name, ".reg_size_z"}, {29'd0, reg_size}, 32'd7, 32'hFFFF_FFFF, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int w_old;
    bus_if.reg_addr = 8'd0; bus_if.rw = 1'b0; bus_if.select = 1'b0;
    model_reset();
    rc_in[2] = 1'b1;
    repeat (8) @(posedge clk_12MHz);
    #1; reset = 1'b0;
    check_idle_z("after_reset");
    do_read(8'd6, 2, "rst_status");
    do_read(8'd7, 2, "rst_timeout");
    do_read(8'd0, 2, "rst_width0");
    wait_us(5);
    #1; rc_in[2] = 1'b0;
    wait_us(20);

    pulse(0, 1500);
    wait_us(5);
    do_read(8'd0, 2, "width0_1500");
    do_read(8'd6, 2, "status_ch0");
    do_read(8'd2, 2, "width2_reset_midpulse");
    pulse(2, 1000);
    wait_us(5);
    do_read(8'd2, 2, "width2_1000");
    do_read(8'd6, 3, "status_ch0_ch2");

    for (int c = 0; c < NUM_CH; c++) begin
      automatic int cc  = c;
      automatic int dly = int'($urandom_range(0, 300));
      automatic int w   = int'($urandom_range(100, 2800));
      fork
        begin
          wait_us(dly);
          pulse(cc, w);
        end
      join_none
    end
    wait fork;
    wait_us(5);
    for (int c = 0; c < NUM_CH; c++) do_read(8'(c), 2, $sformatf("rand_width%0d", c));
    do_read(8'd6, 2, "rand_status");

    pulse(1, 3500);
    wait_us(5);
    do_read(8'd1, 2, "width1_abort");
    do_read(8'd6, 2, "status_after_abort");
    pulse(1, 1200);
    wait_us(5);
    do_read(8'd1, 2, "width1_1200");

    do_write(8'd7, 32'h05, 32'h05, 2);
    pulse(3, 1800);
    wait_us(5);
    do_read(8'd3, 2, "width3_1800");
    wait_us(3500);
    do_read(8'd6, 2, "status_before_timeout");
    wait_us(3000);
    do_read(8'd6, 2, "status_after_timeout");
    do_read(8'd3, 2, "width3_timed_out");
    do_read(8'd7, 2, "timeout_reg_5");
    do_write(8'd7, 32'h00, 32'h00, 2);

    w_old = int'($urandom_range(1500, 2500));
    pulse(0, w_old);
    wait_us(5);
    do_read(8'd0, 2, "width0_before_hold");
    fork
      do_read(8'd0, 3000 * CLK_PER_US, "width0_held");
      begin
        wait_us(200);
        pulse(0, 1100);
      end
    join
    do_read(8'd0, 2, "width0_1100");

    check_idle_z("idle_again");
    do_read(8'h40, 3, "unmapped_0x40");
    do_write(8'd7, 32'h07, 32'h09, 10);
    do_read(8'd7, 2, "single_write");
    do_write(8'd0, 32'h1234, 32'h1234, 3);
    do_read(8'd0, 2, "width0_write_ignored");

    @(posedge clk_12MHz); #1;
    reset = 1'b1;
    repeat (4) @(posedge clk_12MHz);
    #1; reset = 1'b0;
    model_reset();
    do_read(8'd7, 2, "rst2_timeout");
    do_read(8'd6, 2, "rst2_status");
    do_read(8'd0, 2, "rst2_width0");

    repeat (4) @(posedge clk_12MHz);
    cmp("scoreboard_drained", 32'(sb.size()), 32'd0, 32'hFFFF_FFFF, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    repeat (150000) @(posedge clk_12MHz);
    $display("FAIL watchdog: got cycle budget exhausted, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
